instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of the instruction decoder. Holds the program counter and issues word reads to instruction memory through a req/ack handshake. Registers the returned word into the instruction register that drives the decoder's 32-bit Instruction input. Handles stall backpressure and branch redirects. Emits all-zero instruction words (decoded as NOP) whenever no valid instruction is held.

---
 rtl/instruction_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs a req/ack read to instruction memory and holds
// the returned word for the decoder until it is accepted or a redirect drops it.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_Data,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic [31:0] Instruction,
    output logic [31:0] Instruction_PC,
    output logic        Instruction_Valid,
    output logic [15:0] Fetch_Count
);

    typedef enum logic [1:0] {S_FETCH, S_ISSUE, S_FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        req_q, req_d;
    logic        vld_q, vld_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] tgt;
    logic        acked;

    assign tgt   = Branch_Target & ~32'h3;
    assign acked = req_q & Mem_Ack;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (Branch_Taken) begin
                    pc_d    = tgt;
                    instr_d = '0;
                    vld_d   = 1'b0;
                    // an unanswered request must still be drained
                    state_d = (req_q && !Mem_Ack) ? S_FLUSH : S_FETCH;
                end else if (acked) begin
                    instr_d = Mem_Data;
                    ipc_d   = pc_q;
                    vld_d   = 1'b1;
                    pc_d    = pc_q + PC_STEP;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (Branch_Taken) begin
                    pc_d    = tgt;
                    instr_d = '0;
                    vld_d   = 1'b0;
                    state_d = S_FETCH;
                end else if (!Stall) begin
                    cnt_d   = cnt_q + 16'd1;
                    instr_d = '0;
                    vld_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (Branch_Taken) begin
                    pc_d    = tgt;
                    instr_d = '0;
                    vld_d   = 1'b0;
                end
                if (acked) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A pending request is never withdrawn or re-addressed until acked.
        if (req_q && !Mem_Ack) begin
            req_d  = 1'b1;
            addr_d = addr_q;
        end else if (state_d == S_FETCH) begin
            req_d  = 1'b1;
            addr_d = pc_d;
        end else begin
            req_d  = 1'b0;
            addr_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            req_q   <= req_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Mem_Req           = req_q;
    assign Mem_Addr          = addr_q;
    assign Instruction       = instr_q;
    assign Instruction_PC    = ipc_q;
    assign Instruction_Valid = vld_q;
    assign Fetch_Count       = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a memory with random latency plus a
// program-order scoreboard (expected next PC, delivered count, handshake rules).
module tb_instruction_fetch_unit;

    logic        Clock, Reset_n;
    logic        Mem_Req, Mem_Ack, Stall, Branch_Taken, Instruction_Valid;
    logic [31:0] Mem_Addr, Mem_Data, Branch_Target, Instruction, Instruction_PC;
    logic [15:0] Fetch_Count;

    logic        w_req, w_vld;
    logic [31:0] w_addr, w_instr, w_ipc, w_data;
    logic [15:0] w_cnt;

    int          n_chk = 0, n_fail = 0;
    int          lat_cnt = 0, lat_mode = 0;
    logic [31:0] exp_pc = 0;
    logic [15:0] exp_count = 0;
    bit          ovr_en = 0;
    logic [31:0] ovr_addr = 0, ovr_data = 0;

    instruction_fetch_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr),
        .Mem_Ack(Mem_Ack), .Mem_Data(Mem_Data), .Stall(Stall),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
        .Instruction(Instruction), .Instruction_PC(Instruction_PC),
        .Instruction_Valid(Instruction_Valid), .Fetch_Count(Fetch_Count)
    );

    // second instance near the top of the address space, memory always acks at once
    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .Clock(Clock), .Reset_n(Reset_n), .Mem_Req(w_req), .Mem_Addr(w_addr),
        .Mem_Ack(w_req), .Mem_Data(w_data), .Stall(1'b0),
        .Branch_Taken(1'b0), .Branch_Target(32'h0),
        .Instruction(w_instr), .Instruction_PC(w_ipc),
        .Instruction_Valid(w_vld), .Fetch_Count(w_cnt)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] word(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    assign w_data = word(w_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive memory/control, advance the model, then check at edge+1.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt);
        logic        p_req, p_ack, p_vld;
        logic [31:0] p_addr, p_instr;
        if (Mem_Req) begin
            Mem_Ack = (lat_cnt == 0);
            if (lat_cnt != 0) lat_cnt--;
        end else begin
            Mem_Ack = ($urandom_range(0, 3) == 0);
        end
        Mem_Data      = (Mem_Ack && Mem_Req) ? word(Mem_Addr) : $urandom;
        Stall         = st;
        Branch_Taken  = br;
        Branch_Target = tgt;
        p_req = Mem_Req; p_ack = Mem_Ack; p_addr = Mem_Addr;
        p_vld = Instruction_Valid; p_instr = Instruction;
        if (p_vld && !st && !br) exp_count++;
        if (br) exp_pc = tgt & ~32'h3;
        @(posedge Clock); #1;
        if (p_req && !p_ack) begin
            chk("req_hold", Mem_Req, 1);
            chk("addr_hold", Mem_Addr, p_addr);
        end else if (Mem_Req) begin
            chk("req_addr", Mem_Addr, exp_pc);
            lat_cnt = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
        end
        if (!Mem_Req) chk("addr_idle", Mem_Addr, 0);
        if (Instruction_Valid && !p_vld) begin
            chk("ipc", Instruction_PC, exp_pc);
            chk("instr", Instruction, word(exp_pc));
            exp_pc += 4;
        end
        if (p_vld && st && !br) begin
            chk("stall_vld", Instruction_Valid, 1);
            chk("stall_instr", Instruction, p_instr);
        end
        if (!Instruction_Valid) chk("instr_zero", Instruction, 0);
        chk("count", Fetch_Count, exp_count);
    endtask

    task automatic do_reset(input bit check_async);
        #2 Reset_n = 1'b0;
        #1;
        if (check_async) begin
            chk("rst_req", Mem_Req, 0);
            chk("rst_addr", Mem_Addr, 0);
            chk("rst_instr", Instruction, 0);
            chk("rst_ipc", Instruction_PC, 0);
            chk("rst_vld", Instruction_Valid, 0);
            chk("rst_cnt", Fetch_Count, 0);
        end
        Mem_Ack = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0;
        @(posedge Clock); #3;
        Reset_n   = 1'b1;
        exp_pc    = 32'h0;
        exp_count = 16'h0;
        lat_cnt   = 0;
    endtask

    task automatic wait_vld();
        for (int k = 0; k < 20 && !Instruction_Valid; k++) step(1'b0, 1'b0, 32'h0);
        chk("vld_wait", Instruction_Valid, 1);
    endtask

    initial begin
        logic [15:0] c0;
        Reset_n = 1'b0; Mem_Ack = 1'b0; Mem_Data = 32'h0;
        Stall = 1'b0; Branch_Taken = 1'b0; Branch_Target = 32'h0;
        #1;
        do_reset(1'b1);

        // straight-line fetch, immediate acks
        lat_mode = 0;
        step(1'b0, 1'b0, 32'h0);
        chk("t1_req", Mem_Req, 1);
        chk("t1_addr", Mem_Addr, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t1_vld", Instruction_Valid, (i % 2 == 0));
            if (i % 2 == 0) chk("t1_ipc", Instruction_PC, 32'(4 * (i / 2)));
        end
        chk("t1_cnt", Fetch_Count, 3);

        // 5-cycle stall on a held word
        ovr_en = 1; ovr_addr = exp_pc; ovr_data = 32'h1234_5680;
        wait_vld();
        chk("t2_instr", Instruction, 32'h1234_5680);
        c0 = Fetch_Count;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'h0);
            chk("t2_vld", Instruction_Valid, 1);
            chk("t2_instr_hold", Instruction, 32'h1234_5680);
            chk("t2_ipc_hold", Instruction_PC, 32'd12);
            chk("t2_noreq", Mem_Req, 0);
            chk("t2_cnt_hold", Fetch_Count, c0);
        end
        step(1'b0, 1'b0, 32'h0);
        chk("t2_cnt_inc", Fetch_Count, c0 + 16'd1);
        chk("t2_vld_drop", Instruction_Valid, 0);

        // an all-zero word is a real instruction
        ovr_addr = exp_pc; ovr_data = 32'h0;
        wait_vld();
        chk("zw_instr", Instruction, 0);
        c0 = Fetch_Count;
        step(1'b0, 1'b0, 32'h0);
        chk("zw_cnt", Fetch_Count, c0 + 16'd1);
        ovr_en = 0;

        // redirect while holding an instruction
        wait_vld();
        lat_mode = 3;
        c0 = Fetch_Count;
        step(1'b0, 1'b1, 32'h0000_0103);
        chk("t3_vld", Instruction_Valid, 0);
        chk("t3_instr", Instruction, 0);
        chk("t3_req", Mem_Req, 1);
        chk("t3_addr", Mem_Addr, 32'h0000_0100);
        chk("t3_cnt", Fetch_Count, c0);

        // redirect while that request waits 3 cycles for its ack
        step(1'b0, 1'b1, 32'h0000_0200);
        chk("t4_addr_old", Mem_Addr, 32'h0000_0100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0);
            chk("t4_vld", Instruction_Valid, 0);
            chk("t4_req", Mem_Req, 1);
            chk("t4_addr", Mem_Addr, (i < 2) ? 32'h0000_0100 : 32'h0000_0200);
        end

        // reset in the middle of a slow request
        lat_mode = 8;
        wait_vld();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t6_pre_req", Mem_Req, 1);
        do_reset(1'b1);
        lat_mode = -1;
        step(1'b0, 1'b0, 32'h0);
        chk("t6_req", Mem_Req, 1);
        chk("t6_addr", Mem_Addr, 0);

        // PC wrap on the high-reset instance, same reset release
        chk("t5_req", w_req, 1);
        chk("t5_addr", w_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0);
        chk("t5_vld", w_vld, 1);
        chk("t5_ipc", w_ipc, 32'hFFFF_FFFC);
        chk("t5_instr", w_instr, word(32'hFFFF_FFFC));
        step(1'b0, 1'b0, 32'h0);
        chk("t5_wrap_req", w_req, 1);
        chk("t5_wrap_addr", w_addr, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        chk("t5_wrap_ipc", w_ipc, 32'h0);
        chk("t5_wcnt", w_cnt, 1);

        // random stall/branch/latency traffic, targets sometimes near the wrap point
        for (int i = 0; i < 800; i++) begin
            logic        st, br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 11) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            step(st, br, tgt);
        end
        chk("rnd_progress", 32'(Fetch_Count > 16'd20), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
